// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: round-robin shared WIDTH-bit subtractor; define SUB_SATURATE_EN to clamp underflow to 0
module sub_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res,
  output logic [IDW-1:0]          res_id,
  output logic                    borrow
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic [IDW-1:0] ptr, id, win, j;
  logic [IDW:0] s;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  genvar i;
  for (i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
    assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
  end
  assign gnt = state == EXEC ? NREQ'(1) << id : '0;
  assign res_valid = state == RESP;
  // winner: first requester at or after ptr, scanning downward so the nearest one is assigned last
  always_comb begin
    win = '0;
    s = '0;
    j = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IDW+1)'(k);
      j = s >= (IDW+1)'(NREQ) ? IDW'(s - (IDW+1)'(NREQ)) : IDW'(s);
      win = req[j] ? j : win;
    end
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  // next state: grant from IDLE, one compute cycle, hold result until accepted
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (|req ? EXEC : IDLE) :
                state == EXEC ? RESP : (res_ready ? IDLE : RESP);
  end
  // operand capture, result computation and round-robin pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      id <= '0;
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      res_id <= '0;
      borrow <= 1'b0;
    end else begin
      if (state == IDLE && |req) begin
        op_a <= a_arr[win];
        op_b <= b_arr[win];
        id <= win;
      end
      if (state == EXEC) begin
`ifdef SUB_SATURATE_EN
        res <= op_a < op_b ? '0 : op_a - op_b;
`else
        res <= op_a - op_b;
`endif
        borrow <= op_a < op_b;
        res_id <= id;
      end
      if (state == RESP && res_ready)
        ptr <= id == IDW'(NREQ-1) ? '0 : id + 1'b1;
    end
  end
endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb_sub_share_arbiter: randomized check of sub_share_arbiter against a transaction-level model
module tb_sub_share_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ = 4;
  localparam int IDW = $clog2(NREQ);
  localparam int MASK = (1 << WIDTH) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic [NREQ-1:0] gnt;
  logic res_valid, res_ready;
  logic [WIDTH-1:0] res;
  logic [IDW-1:0] res_id;
  logic borrow;
  int checks = 0;
  int passed = 0;
  bit pend [NREQ];
  int av [NREQ];
  int bv [NREQ];
  int mptr = 0;

  always #5 clk = ~clk;

  sub_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .res_id(res_id), .borrow(borrow)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_res(input int a, input int b);
`ifdef SUB_SATURATE_EN
    return a < b ? 0 : a - b;
`else
    return (a - b) & MASK;
`endif
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = pend[i];
      a_in[i*WIDTH +: WIDTH] = WIDTH'(av[i]);
      b_in[i*WIDTH +: WIDTH] = WIDTH'(bv[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_operands(input int i);
    int r;
    r = $urandom_range(0, 7);
    av[i] = r == 1 ? 0 : $urandom_range(0, MASK);
    bv[i] = r == 0 ? av[i] : r == 1 ? MASK : $urandom_range(0, MASK);
  endtask

  task automatic set_req(input int i, input int a, input int b);
    pend[i] = 1'b1;
    av[i] = a;
    bv[i] = b;
  endtask

  // one full transaction from an idle DUT; rnd lets the winner re-request and others join
  task automatic op(input int stall, input bit rnd);
    int w, ea, eb, er;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && pend[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
    ea = av[w];
    eb = bv[w];
    er = exp_res(ea, eb);
    res_ready = 1'($urandom_range(0, 1));
    drive();
    cycle();
    chk("gnt", int'(gnt), 1 << w);
    chk("valid_at_gnt", int'(res_valid), 0);
    pend[w] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    if (pend[w]) new_operands(w);
    if (rnd)
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          new_operands(i);
        end
    drive();
    res_ready = 1'($urandom_range(0, 1));
    cycle();
    chk("gnt_pulse", int'(gnt), 0);
    chk("res_valid", int'(res_valid), 1);
    chk("res", int'(res), er);
    chk("res_id", int'(res_id), w);
    chk("borrow", int'(borrow), int'(ea < eb));
    res_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      cycle();
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_res", int'(res), er);
      chk("hold_id", int'(res_id), w);
      chk("hold_borrow", int'(borrow), int'(ea < eb));
      chk("hold_gnt", int'(gnt), 0);
    end
    res_ready = 1'b1;
    cycle();
    chk("accept_valid", int'(res_valid), 0);
    chk("accept_gnt", int'(gnt), 0);
    chk("keep_res", int'(res), er);
    res_ready = 1'b0;
    mptr = (w + 1) % NREQ;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_res", int'(res), 0);
    chk("rst_id", int'(res_id), 0);
    chk("rst_borrow", int'(borrow), 0);
    rst = 1'b0;
    mptr = 0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      av[i] = 0;
      bv[i] = 0;
    end
    res_ready = 1'b0;
    drive();
    cycle();
    do_reset();
    cycle();
    chk("idle_gnt", int'(gnt), 0);
    chk("idle_valid", int'(res_valid), 0);
    set_req(0, 200, 55);
    op(0, 1'b0);
    set_req(2, 5, 10);
    op(0, 1'b0);
    set_req(0, 7, 7);
    op(1, 1'b0);
    set_req(3, 0, MASK);
    op(0, 1'b0);
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, i + 20, i);
    for (int i = 0; i < NREQ; i++) op(0, 1'b0);
    set_req(1, 9, 3);
    op(5, 1'b0);
    set_req(2, 100, 1);
    op(0, 1'b0);
    set_req(1, 11, 1);
    set_req(3, 12, 2);
    op(0, 1'b0);
    op(0, 1'b0);
    set_req(1, 50, 8);
    op(0, 1'b0);
    set_req(1, 40, 4);
    drive();
    cycle();
    chk("midop_gnt", int'(gnt), 2);
    pend[1] = 1'b0;
    set_req(2, 30, 3);
    drive();
    cycle();
    chk("midop_valid", int'(res_valid), 1);
    do_reset();
    set_req(1, 60, 6);
    op(0, 1'b0);
    op(0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          new_operands(i);
        end
      if (pend[0] || pend[1] || pend[2] || pend[3]) op($urandom_range(0, 3), 1'b1);
      else begin
        res_ready = 1'($urandom_range(0, 1));
        drive();
        cycle();
        chk("rand_idle_gnt", int'(gnt), 0);
        chk("rand_idle_valid", int'(res_valid), 0);
        res_ready = 1'b0;
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sub_share_arbiter.md
Name: sub_share_arbiter

Overview:
- Shares one WIDTH-bit unsigned subtractor (A − B, modulo 2^WIDTH) between NREQ requesters.
- Round-robin arbitration selects one requester, latches its operand pair, computes the difference and presents a registered result with the winner's ID.
- Result uses valid/ready backpressure.
- Sits between requesting datapath units and the shared subtract resource.

Parameters:
- WIDTH, 8, operand/result width in bits.
- NREQ, 4, number of requesters; legal 2..8.
- IDW (localparam), $clog2(NREQ), requester ID width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held with operands until matching gnt seen.
- a_in  input  NREQ*WIDTH  minuend per requester; requester i at bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  subtrahend per requester, same packing.
- gnt  output  NREQ  one-hot, one-cycle pulse; operands of that requester captured.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts result.
- res  output  WIDTH  difference.
- res_id  output  IDW  index of requester owning res.
- borrow  output  1  1 when A < B for the presented result.

Behaviour:
- Reset: one clock; reset and polarity as decided (synchronous, active-high).
  - rst high at an edge: state=IDLE, ptr=0, gnt=0, res_valid=0, res=0, res_id=0, borrow=0, operand registers=0.
  - Reset mid-operation (any state) discards captured operands and any pending result; no gnt/res_valid after reset until a new request.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req==0: stay.
  - Else winner = first set bit of req searching from index ptr upward, wrapping modulo NREQ.
  - On the edge: op_a/op_b <= winner operands, id <= winner, gnt <= onehot(winner), go to EXEC.
- EXEC:
  - On the edge: gnt <= 0; res <= op_a − op_b truncated to WIDTH; borrow <= (op_a < op_b); res_id <= id; res_valid <= 1; go to RESP.
- RESP:
  - res, res_id, borrow held stable while res_valid=1 and res_ready=0.
  - On an edge with res_ready=1: res_valid <= 0, ptr <= (id+1) mod NREQ, go to IDLE.
  - res/res_id/borrow keep their last value after acceptance.
- Latency: req sampled at edge E0 → gnt high E0..E1 → res_valid high from E1 → earliest accept at E2 → IDLE. Minimum 3 cycles per operation.
- Requester protocol:
  - Requester drops req (or presents a new operand pair) in the cycle it sees gnt.
  - req changes in EXEC/RESP are ignored.
  - Operands are sampled only at the IDLE grant edge.
- res_ready is ignored outside RESP; no combinational path from res_ready to res_valid.
- Boundaries:
  - A==B gives res=0, borrow=0.
  - A=0, B=2^WIDTH−1 gives res=1, borrow=1.
  - Index NREQ−1 wraps ptr to 0.
  - All requests simultaneous: served in ptr order, each exactly once per round.
  - Single persistent requester is served repeatedly; no starvation of others once they assert req.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: when op_a < op_b, res = 0 (clamped); borrow still reports 1.
- Undefined: res wraps modulo 2^WIDTH.
- Arbitration, latency and handshake are identical in both builds.

Test Plan:
- Single request, req=0001, a0=200, b0=55, res_ready=1 → gnt=0001 one cycle; next cycle res_valid=1, res=145, res_id=0, borrow=0; IDLE after 3 cycles total.
- Underflow, requester 2, a=5, b=10 → res=251, borrow=1. With SUB_SATURATE_EN: res=0, borrow=1.
- req=1111 held, each dropping after its gnt, operands a=i+20, b=i → grants in order 0,1,2,3; each res=20 with res_id 0..3.
- Backpressure: res_ready=0 for 5 cycles in RESP with a=9, b=3 → res=6, res_id and borrow stable, res_valid stays 1, no new gnt. res_ready=1 → accepted, next grant ≥1 cycle later.
- Fairness: after serving requester 2 (ptr=3), req=1010 → gnt=1000 first, then gnt=0010.
- Reset mid-op: rst asserted in RESP with res_valid=1 → next cycle res_valid=0, gnt=0, ptr=0. With req=0110, first grant is requester 1.
